// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressed RAM initiator: access sizes, FSM states
// and lane helpers.
package mem_pkg;
   localparam int WORD_BYTES = 8;
   localparam int OFF_W      = 3;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_e;

   // Right-aligned byte-lane mask covering one access of the given size.
   function automatic logic [63:0] sizeMask(input size_e sz);
      unique case (sz)
         SZ_B:    sizeMask = 64'h0000_0000_0000_00FF;
         SZ_H:    sizeMask = 64'h0000_0000_0000_FFFF;
         SZ_W:    sizeMask = 64'h0000_0000_FFFF_FFFF;
         default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   function automatic logic isMisaligned(input logic [OFF_W-1:0] off, input size_e sz);
      unique case (sz)
         SZ_B:    isMisaligned = 1'b0;
         SZ_H:    isMisaligned = off[0];
         SZ_W:    isMisaligned = (off[1:0] != 2'b00);
         default: isMisaligned = (off != '0);
      endcase
   endfunction
endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for one 64-bit RAM word: sub-word load extraction with
// optional sign extension, and the merged word for a sub-word store.
module lane_align
   import mem_pkg::*;
(
   input  logic [63:0]      word,
   input  logic [OFF_W-1:0] offset,
   input  size_e            size,
   input  logic             isSigned,
   input  logic [63:0]      wdata,
   output logic [63:0]      loadVal,
   output logic [63:0]      storeWord
);
   logic [5:0]  shamt;
   logic [63:0] shifted;
   logic [63:0] laneMask;

   assign shamt = {offset, 3'b000};

   always_comb begin
      shifted  = word >> shamt;
      laneMask = sizeMask(size) << shamt;
      unique case (size)
         SZ_B:    loadVal = {{56{isSigned & shifted[7]}},  shifted[7:0]};
         SZ_H:    loadVal = {{48{isSigned & shifted[15]}}, shifted[15:0]};
         SZ_W:    loadVal = {{32{isSigned & shifted[31]}}, shifted[31:0]};
         default: loadVal = shifted;
      endcase
      storeWord = (word & ~laneMask) | ((wdata << shamt) & laneMask);
   end
endmodule

// File: rtl/ram_master.sv
// Load/store initiator for a single-port 64-bit RAM without byte enables;
// sub-word stores are done as read-modify-write.
module ram_master
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+2:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [63:0]       ram_writeData,
   output logic              ram_writeEn,
   input  logic [63:0]       ram_readData
);
   state_e           state;
   logic             lWrite;
   size_e            lSize;
   logic             lSigned;
   logic [OFF_W-1:0] lOffset;
   logic [63:0]      lWdata;
   logic [63:0]      rdbuf;
   logic [63:0]      alignSrc;
   logic [63:0]      loadVal;
   logic [63:0]      storeWord;
   size_e            reqSize;
   logic             reqMis;

   assign reqSize = size_e'(req_size);
   assign reqMis  = isMisaligned(req_addr[OFF_W-1:0], reqSize);

   // The live RAM word feeds the load path in RD; the buffered copy feeds the merge in WR.
   assign alignSrc = (state == WR) ? rdbuf : ram_readData;

   lane_align uAlign (
      .word      (alignSrc),
      .offset    (lOffset),
      .size      (lSize),
      .isSigned  (lSigned),
      .wdata     (lWdata),
      .loadVal   (loadVal),
      .storeWord (storeWord)
   );

   assign req_ready     = (state == IDLE);
   assign rsp_valid     = (state == RESP);
   assign ram_writeEn   = (state == WR) & rst_n;
   assign ram_writeData = (state != WR) ? 64'd0 : ((lSize == SZ_D) ? lWdata : storeWord);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ram_adr   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         lWrite    <= 1'b0;
         lSize     <= SZ_B;
         lSigned   <= 1'b0;
         lOffset   <= '0;
         lWdata    <= '0;
         rdbuf     <= '0;
      end else begin
         unique case (state)
            IDLE: if (req_valid) begin
               lWrite    <= req_write;
               lSize     <= reqSize;
               lSigned   <= req_signed;
               lOffset   <= req_addr[OFF_W-1:0];
               lWdata    <= req_wdata;
               ram_adr   <= req_addr[ADDR_W+2:OFF_W];
               rsp_rdata <= '0;
               rsp_err   <= reqMis;
               if (reqMis)                           state <= RESP;
               else if (req_write && reqSize == SZ_D) state <= WR;
               else                                  state <= RD;
            end
            RD: begin
               rdbuf <= ram_readData;
               if (lWrite) state <= WR;
               else begin
                  rsp_rdata <= loadVal;
                  state     <= RESP;
               end
            end
            WR:   state <= RESP;
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_master.sv
// Randomized self-checking bench for ram_master against a byte-array memory model.
module tb_ram_master;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rstN;
   logic          reqValid, reqReady, reqWrite, reqSigned;
   logic [1:0]    reqSize;
   logic [AW+2:0] reqAddr;
   logic [63:0]   reqWdata;
   logic          rspValid, rspReady, rspErr;
   logic [63:0]   rspRdata;
   logic [AW-1:0] ramAdr;
   logic [63:0]   ramWriteData, ramReadData;
   logic          ramWriteEn;

   logic [63:0] mem [0:(1<<AW)-1];
   logic [7:0]  refB [0:(8<<AW)-1];
   int          writeCnt = 0;
   int          nTests = 0;
   int          nFail = 0;

   ram_master #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rstN),
      .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
      .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr),
      .ram_adr(ramAdr), .ram_writeData(ramWriteData), .ram_writeEn(ramWriteEn),
      .ram_readData(ramReadData)
   );

   always #5 clk = ~clk;

   assign ramReadData = mem[ramAdr];
   always @(posedge clk) begin
      if (ramWriteEn) begin
         mem[ramAdr] <= ramWriteData;
         writeCnt    <= writeCnt + 1;
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] refWord(input int w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = refB[8*w + i];
      return v;
   endfunction

   function automatic logic [63:0] refLoad(input int a, input int n, input logic sg);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refB[a + i];
      if (sg && n < 8 && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic preload(input int w, input logic [63:0] val);
      mem[w] = val;
      for (int i = 0; i < 8; i++) refB[8*w + i] = val[8*i +: 8];
   endtask

   task automatic doTxn(input logic w, input logic [1:0] sz, input logic sg,
                        input int addr, input logic [63:0] wd, input int bp);
      int          n, lat, expLat, w0, guard;
      logic        mis;
      logic [63:0] expData;
      n       = 1 << sz;
      mis     = (addr % n) != 0;
      expLat  = mis ? 1 : (!w ? 2 : (sz == 2'd3 ? 2 : 3));
      expData = (mis || w) ? 64'd0 : refLoad(addr, n, sg);
      w0      = writeCnt;

      @(negedge clk);
      guard = 0;
      while (!reqReady && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      checkVal("req_ready_idle", reqReady, 1);
      reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
      reqAddr = addr[AW+2:0]; reqWdata = wd;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      lat = 1;
      while (!rspValid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      checkVal("latency", lat, expLat);
      checkVal("rsp_err", rspErr, mis);
      checkVal("rsp_rdata", rspRdata, expData);

      for (int k = 0; k < bp; k++) begin
         reqValid = 1'b1; reqWrite = $urandom_range(0, 1); reqSize = 2'($urandom_range(0, 3));
         reqAddr = (AW+3)'($urandom); reqWdata = {$urandom, $urandom};
         @(negedge clk);
         checkVal("bp_rsp_valid", rspValid, 1);
         checkVal("bp_rsp_rdata", rspRdata, expData);
         checkVal("bp_req_ready", reqReady, 0);
      end
      reqValid  = 1'b0;
      rspReady  = 1'b1;
      @(negedge clk);
      rspReady  = 1'b0;

      if (w && !mis)
         for (int i = 0; i < n; i++) refB[addr + i] = wd[8*i +: 8];
      checkVal("write_count", 64'(writeCnt - w0), (w && !mis) ? 64'd1 : 64'd0);
      checkVal("mem_word", mem[addr / 8], refWord(addr / 8));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0;
      rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
      reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
      for (int i = 0; i < (1 << AW); i++) preload(i, {$urandom, $urandom});

      repeat (3) @(negedge clk);
      checkVal("rst_req_ready", reqReady, 1);
      checkVal("rst_rsp_valid", rspValid, 0);
      checkVal("rst_wen", ramWriteEn, 0);
      checkVal("rst_wdata", ramWriteData, 0);
      checkVal("rst_adr", ramAdr, 0);
      checkVal("rst_rdata", rspRdata, 0);
      checkVal("rst_err", rspErr, 0);
      rstN = 1'b1;

      preload(5, 64'h1122334455667788);
      doTxn(1'b0, 2'd3, 1'b0, 'h28, 64'd0, 0);
      preload(2, 64'h00000000000080FF);
      doTxn(1'b0, 2'd0, 1'b1, 'h11, 64'd0, 0);
      checkVal("signed_byte_abs", rspRdata, 64'hFFFFFFFFFFFFFF80);
      doTxn(1'b0, 2'd0, 1'b0, 'h11, 64'd0, 0);
      checkVal("unsigned_byte_abs", rspRdata, 64'h80);
      preload(3, 64'hAAAAAAAAAAAAAAAA);
      doTxn(1'b1, 2'd1, 1'b0, 'h1A, 64'h1234, 0);
      checkVal("rmw_abs", mem[3], 64'hAAAAAAAA1234AAAA);
      doTxn(1'b1, 2'd2, 1'b0, 'h02, 64'hDEADBEEF, 0);
      doTxn(1'b0, 2'd2, 1'b1, 'h1C, 64'd0, 4);
      doTxn(1'b1, 2'd3, 1'b0, 'h40, 64'h0123456789ABCDEF, 2);

      // Reset asserted during the WR cycle of a read-modify-write store.
      preload(3, 64'hAAAAAAAAAAAAAAAA);
      w0 = writeCnt;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd1; reqSigned = 1'b0;
      reqAddr = 'h1A; reqWdata = 64'h1234;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      checkVal("wr_wen_high", ramWriteEn, 1);
      rstN = 1'b0;
      #1;
      checkVal("wr_wen_gated", ramWriteEn, 0);
      @(negedge clk);
      checkVal("rstmid_rsp_valid", rspValid, 0);
      checkVal("rstmid_req_ready", reqReady, 1);
      checkVal("rstmid_writes", 64'(writeCnt - w0), 0);
      checkVal("rstmid_mem", mem[3], refWord(3));
      rstN = 1'b1;

      for (int t = 0; t < 80; t++) begin
         logic [1:0] sz;
         int         a;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom_range(0, 8*16 - 1);
         if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
         doTxn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
               {$urandom, $urandom}, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
